// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, sync byte
// and error codes reported on err_code.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } boot_state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHK  = 2'd1,
      ERR_LEN  = 2'd2,
      ERR_TMO  = 2'd3
   } boot_err_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles WIDTH/8 received bytes into one word and pulses word_valid on the
// cycle after the final byte of each word.
module byte_packer
   import boot_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       byte_in,
   input  logic             strobe,
   input  logic             clear,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             last_byte
);

   localparam int unsigned WORD_BYTES = WIDTH / 8;
   localparam int unsigned CW         = cnt_width(WORD_BYTES);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shifted;

   assign last_byte = (cnt == CW'(WORD_BYTES - 1));

   // Little-endian shifts new bytes in from the top so the first byte ends
   // at [7:0]; big-endian shifts in from the bottom.
   always_comb begin
      shifted = '0;
      if (BIG_ENDIAN)
         shifted = (word << 8) | WIDTH'(byte_in);
      else
         shifted = (word >> 8) | (WIDTH'(byte_in) << (WIDTH - 8));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            cnt <= '0;
         end else if (strobe) begin
            word <= shifted;
            if (last_byte) begin
               cnt        <= '0;
               word_valid <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART program loader: parses SYNC/LEN/payload/CHK, writes packed words
// into text memory and holds the CPU in reset until a frame verifies.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter bit          BIG_ENDIAN = 1'b0,
   parameter int unsigned TIMEOUT    = 5_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   input  logic                  boot_req,
   output logic                  cpu_rst,
   output logic                  text_we,
   output logic [ADDR_WIDTH-1:0] text_waddr,
   output logic [WIDTH-1:0]      text_wdata,
   output logic                  loaded,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int unsigned TW  = cnt_width(TIMEOUT);
   localparam int unsigned CAP = 32'd1 << ADDR_WIDTH;

   boot_state_t           state, state_n;
   boot_err_t             err_q, err_n;
   logic [7:0]            len_lo_q;
   logic [ADDR_WIDTH:0]   len_m1_q;
   logic [ADDR_WIDTH:0]   word_idx_q;
   logic [7:0]            chk_q;
   logic [TW-1:0]         idle_q;
   logic [15:0]           n_full;
   logic                  active, timed_out, start, pay_byte, last_byte;

   assign n_full    = {rx_data, len_lo_q};
   assign active    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_PAYLOAD) || (state == ST_CHECK);
   assign timed_out = (idle_q == TW'(TIMEOUT - 1)) && !rx_done;
   assign pay_byte  = (state == ST_PAYLOAD) && rx_done && !boot_req;
   assign err_code  = err_q;

   always_comb begin
      state_n = state;
      err_n   = err_q;
      start   = 1'b0;
      if (boot_req) begin
         state_n = ST_IDLE;
         err_n   = ERR_NONE;
      end else if (active && timed_out) begin
         state_n = ST_ERROR;
         err_n   = ERR_TMO;
      end else if (rx_done) begin
         case (state)
            ST_IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_n = ST_LEN_LO;
                  start   = 1'b1;
               end
            end
            ST_LEN_LO: state_n = ST_LEN_HI;
            ST_LEN_HI: begin
               if (32'(n_full) > CAP) begin
                  state_n = ST_ERROR;
                  err_n   = ERR_LEN;
               end else if (n_full == 16'd0) begin
                  state_n = ST_CHECK;
               end else begin
                  state_n = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (last_byte && (word_idx_q == len_m1_q))
                  state_n = ST_CHECK;
            end
            ST_CHECK: begin
               if (rx_data == chk_q) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_ERROR;
                  err_n   = ERR_CHK;
               end
            end
            ST_ERROR: begin
               if (rx_data == SYNC_BYTE) begin
                  state_n = ST_LEN_LO;
                  err_n   = ERR_NONE;
                  start   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs are registered from the next state so they change on the
   // same edge as the state register, without a path from the rx inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         err_q    <= ERR_NONE;
         cpu_rst  <= 1'b1;
         loaded   <= 1'b0;
         err      <= 1'b0;
         len_lo_q <= '0;
         len_m1_q <= '0;
      end else begin
         state   <= state_n;
         err_q   <= err_n;
         cpu_rst <= (state_n != ST_DONE);
         loaded  <= (state_n == ST_DONE);
         err     <= (state_n == ST_ERROR);
         if ((state == ST_LEN_LO) && rx_done)
            len_lo_q <= rx_data;
         if ((state == ST_LEN_HI) && rx_done)
            len_m1_q <= (ADDR_WIDTH + 1)'(n_full - 16'd1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q      <= '0;
         word_idx_q <= '0;
         text_waddr <= '0;
         idle_q     <= '0;
      end else begin
         if (start) begin
            chk_q      <= '0;
            word_idx_q <= '0;
         end else if (pay_byte) begin
            chk_q <= chk_q ^ rx_data;
            if (last_byte) begin
               text_waddr <= word_idx_q[ADDR_WIDTH-1:0];
               word_idx_q <= word_idx_q + 1'b1;
            end
         end
         if (rx_done || !active)
            idle_q <= '0;
         else
            idle_q <= idle_q + 1'b1;
      end
   end

   byte_packer #(
      .WIDTH      (WIDTH),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (rx_data),
      .strobe     (pay_byte),
      .clear      (state != ST_PAYLOAD),
      .word       (text_wdata),
      .word_valid (text_we),
      .last_byte  (last_byte)
   );

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a 32-bit little-endian instance and a
// 16-bit big-endian instance, each checked against a frame-level model.
module tb_uart_boot_loader;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_le_t;

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
   } wr_be_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0, rx_data_b = '0;
   logic        rx_done = 1'b0, rx_done_b = 1'b0;
   logic        boot_req = 1'b0, boot_req_b = 1'b0;

   logic        cpu_rst, text_we, loaded, err;
   logic [7:0]  text_waddr;
   logic [31:0] text_wdata;
   logic [1:0]  err_code;

   logic        cpu_rst_b, text_we_b, loaded_b, err_b;
   logic [3:0]  text_waddr_b;
   logic [15:0] text_wdata_b;
   logic [1:0]  err_code_b;

   int unsigned checks = 0;
   int unsigned failures = 0;

   wr_le_t le_q[$];
   wr_be_t be_q[$];

   always #5 clk = ~clk;

   uart_boot_loader #(
      .WIDTH(32), .ADDR_WIDTH(8), .BIG_ENDIAN(1'b0), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
      .boot_req(boot_req), .cpu_rst(cpu_rst), .text_we(text_we),
      .text_waddr(text_waddr), .text_wdata(text_wdata), .loaded(loaded),
      .err(err), .err_code(err_code)
   );

   uart_boot_loader #(
      .WIDTH(16), .ADDR_WIDTH(4), .BIG_ENDIAN(1'b1), .TIMEOUT(100)
   ) dut_be (
      .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_done(rx_done_b),
      .boot_req(boot_req_b), .cpu_rst(cpu_rst_b), .text_we(text_we_b),
      .text_waddr(text_waddr_b), .text_wdata(text_wdata_b), .loaded(loaded_b),
      .err(err_b), .err_code(err_code_b)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Write monitors: every text_we must match the oldest expected write.
   always @(negedge clk) begin
      if (text_we === 1'b1) begin
         if (le_q.size() == 0) begin
            check("le_unexpected_write", 64'(text_waddr), 64'hFFFF);
         end else begin
            wr_le_t e;
            e = le_q.pop_front();
            check("le_waddr", 64'(text_waddr), 64'(e.a));
            check("le_wdata", 64'(text_wdata), 64'(e.d));
         end
      end
      if (text_we_b === 1'b1) begin
         if (be_q.size() == 0) begin
            check("be_unexpected_write", 64'(text_waddr_b), 64'hFFFF);
         end else begin
            wr_be_t e;
            e = be_q.pop_front();
            check("be_waddr", 64'(text_waddr_b), 64'(e.a));
            check("be_wdata", 64'(text_wdata_b), 64'(e.d));
         end
      end
   end

   task automatic send_byte(input bit sel, input logic [7:0] b, input int unsigned gap);
      @(posedge clk); #1;
      if (sel) begin
         rx_data_b = b; rx_done_b = 1'b1;
      end else begin
         rx_data = b; rx_done = 1'b1;
      end
      @(posedge clk); #1;
      rx_done = 1'b0; rx_done_b = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] fr[$]);
      for (int i = 0; i < fr.size(); i++)
         send_byte(1'b0, fr[i], (i == fr.size() - 1) ? 0 : $urandom_range(0, 3));
   endtask

   task automatic pulse_boot_req();
      @(posedge clk); #1 boot_req = 1'b1;
      @(posedge clk); #1 boot_req = 1'b0;
      check("boot_req_cpu_rst", 64'(cpu_rst), 64'd1);
      check("boot_req_loaded", 64'(loaded), 64'd0);
   endtask

   // Frame-level reference: decode length, group payload into little-endian
   // 32-bit words, XOR the payload, and predict the final error code.
   task automatic model_frame(input logic [7:0] fr[$], output logic [1:0] code);
      int unsigned n;
      logic [7:0]  x;
      int unsigned base;
      n = {fr[2], fr[1]};
      if (n > 256) begin
         code = 2'd2;
         return;
      end
      x = 8'h00;
      for (int unsigned i = 0; i < n; i++) begin
         wr_le_t w;
         base = 3 + 4 * i;
         w.a = 8'(i);
         w.d = {fr[base+3], fr[base+2], fr[base+1], fr[base]};
         le_q.push_back(w);
         x = x ^ fr[base] ^ fr[base+1] ^ fr[base+2] ^ fr[base+3];
      end
      code = (fr[3 + 4 * n] == x) ? 2'd0 : 2'd1;
   endtask

   task automatic make_frame(input int unsigned n, input bit bad, output logic [7:0] fr[$]);
      logic [7:0] x, b;
      fr = {};
      fr.push_back(8'hA5);
      fr.push_back(n[7:0]);
      fr.push_back(n[15:8]);
      x = 8'h00;
      repeat (n * 4) begin
         b = 8'($urandom);
         fr.push_back(b);
         x = x ^ b;
      end
      fr.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
   endtask

   task automatic check_status(input string nm, input logic [1:0] code);
      check({nm, ".loaded"}, 64'(loaded), 64'(code == 2'd0));
      check({nm, ".cpu_rst"}, 64'(cpu_rst), 64'(code != 2'd0));
      check({nm, ".err"}, 64'(err), 64'(code != 2'd0));
      check({nm, ".err_code"}, 64'(err_code), 64'(code));
   endtask

   task automatic run_frame(input string nm, input logic [7:0] fr[$]);
      logic [1:0] code;
      model_frame(fr, code);
      send_frame(fr);
      check_status(nm, code);
   endtask

   initial begin
      #20_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [7:0]  fr[$];
      int unsigned cyc;

      #23;
      check("rst.cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst.text_we", 64'(text_we), 64'd0);
      check("rst.text_waddr", 64'(text_waddr), 64'd0);
      check("rst.text_wdata", 64'(text_wdata), 64'd0);
      check("rst.loaded", 64'(loaded), 64'd0);
      check("rst.err", 64'(err), 64'd0);
      check("rst.err_code", 64'(err_code), 64'd0);
      check("rst.be_cpu_rst", 64'(cpu_rst_b), 64'd1);
      rst = 1'b0;

      fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_frame("basic", fr);

      pulse_boot_req();
      fr[11] = 8'h91;
      run_frame("bad_chk", fr);

      make_frame(3, 1'b0, fr);
      run_frame("after_err", fr);

      pulse_boot_req();
      fr = '{8'hA5, 8'h01, 8'h01};
      run_frame("len_ovf", fr);

      make_frame(256, 1'b0, fr);
      run_frame("full_256", fr);

      pulse_boot_req();
      send_byte(1'b0, 8'hA5, 0);
      send_byte(1'b0, 8'h02, 0);
      cyc = 0;
      while (!err && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("timeout_cycles", 64'(cyc), 64'd100);
      check("timeout_code", 64'(err_code), 64'd3);
      check("timeout_cpu_rst", 64'(cpu_rst), 64'd1);

      fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame("empty", fr);

      // boot_req beats a coincident sync byte in DONE
      @(posedge clk); #1;
      boot_req = 1'b1; rx_data = 8'hA5; rx_done = 1'b1;
      @(posedge clk); #1;
      boot_req = 1'b0; rx_done = 1'b0;
      check("prio.cpu_rst", 64'(cpu_rst), 64'd1);
      check("prio.loaded", 64'(loaded), 64'd0);
      send_byte(1'b0, 8'h00, 0);
      send_byte(1'b0, 8'h00, 0);
      send_byte(1'b0, 8'h00, 0);
      check("prio.dropped_loaded", 64'(loaded), 64'd0);
      check("prio.dropped_err", 64'(err), 64'd0);

      for (int k = 0; k < 8; k++) begin
         pulse_boot_req();
         make_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0), fr);
         run_frame("random", fr);
      end

      // Reset in the middle of the third word of a 3-word frame.
      pulse_boot_req();
      make_frame(3, 1'b0, fr);
      for (int i = 0; i < 2; i++) begin
         wr_le_t w;
         w.a = 8'(i);
         w.d = {fr[6+4*i], fr[5+4*i], fr[4+4*i], fr[3+4*i]};
         le_q.push_back(w);
      end
      for (int i = 0; i < 13; i++)
         send_byte(1'b0, fr[i], $urandom_range(0, 2));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst.cpu_rst", 64'(cpu_rst), 64'd1);
      check("midrst.text_we", 64'(text_we), 64'd0);
      check("midrst.text_waddr", 64'(text_waddr), 64'd0);
      check("midrst.text_wdata", 64'(text_wdata), 64'd0);
      check("midrst.loaded", 64'(loaded), 64'd0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (3) send_byte(1'b0, 8'h11, 0);
      check("midrst.after_loaded", 64'(loaded), 64'd0);

      // Big-endian 16-bit instance
      begin
         wr_be_t w;
         w.a = 4'd0;
         w.d = 16'h1234;
         be_q.push_back(w);
      end
      send_byte(1'b1, 8'hA5, 1);
      send_byte(1'b1, 8'h01, 0);
      send_byte(1'b1, 8'h00, 2);
      send_byte(1'b1, 8'h12, 0);
      send_byte(1'b1, 8'h34, 1);
      send_byte(1'b1, 8'h26, 0);
      check("be.loaded", 64'(loaded_b), 64'd1);
      check("be.cpu_rst", 64'(cpu_rst_b), 64'd0);
      check("be.err", 64'(err_b), 64'd0);

      repeat (4) @(posedge clk);
      check("le_pending_writes", 64'(le_q.size()), 64'd0);
      check("be_pending_writes", 64'(be_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Receives a framed program image as a byte stream from `rx_controller` (`RX_DATA`/`RX_DONE`).
- Packs the bytes into instruction words and writes them through the `text_mem` write port.
- Holds the processor in reset while loading, and releases it once a frame passes its checksum.
- Sits at top level between `rx_controller`, `text_mem` and the processor `RST` input. It generalises the single-word, fixed-size loading path to any word width, depth and byte order, with framing, length check, checksum and timeout.

Parameters:
- WIDTH, 32: instruction word width in bits; must be a multiple of 8. WORD_BYTES = WIDTH/8.
- ADDR_WIDTH, 8: text memory word-address width; capacity is 2^ADDR_WIDTH words.
- BIG_ENDIAN, 0: 0 = first byte of a word goes to bits [7:0]; 1 = first byte goes to [WIDTH-1:WIDTH-8].
- TIMEOUT, 5_000_000: maximum idle clock cycles between bytes inside a frame (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_done = 1
- rx_done  in  1  one-cycle strobe per received byte
- boot_req  in  1  request a reload: returns the block to IDLE and re-holds the CPU
- cpu_rst  out  1  processor reset hold, OR-ed with ~KEY[0] at top level
- text_we  out  1  text memory write strobe, one cycle per word
- text_waddr  out  ADDR_WIDTH  word address of the write
- text_wdata  out  WIDTH  assembled word
- loaded  out  1  high in DONE
- err  out  1  high in ERROR
- err_code  out  2  0 none, 1 checksum, 2 length overflow, 3 timeout

Behaviour:
- Frame format: SYNC 0xA5, LEN_LO, LEN_HI (16-bit word count N, little-endian), N*WORD_BYTES payload bytes, CHK.
- CHK is the XOR of the payload bytes only; when N = 0 it must be 0x00.
- Reset values: state IDLE, cpu_rst=1, text_we=0, text_waddr=0, text_wdata=0, loaded=0, err=0, err_code=0. Reset mid-frame aborts the frame; words already written are not erased.
- States: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR. Transitions advance only on rx_done, except boot_req and timeout.
- IDLE: 0xA5 -> LEN_LO. Any other byte is ignored. Clears the checksum, byte counter and word index.
- LEN_LO: latch the low byte -> LEN_HI.
- LEN_HI: evaluate N.
  - N > 2^ADDR_WIDTH -> ERROR, code 2.
  - N = 0 -> CHECK.
  - else -> PAYLOAD.
- PAYLOAD:
  - Each byte shifts into the packer per BIG_ENDIAN and XORs into the checksum.
  - On the WORD_BYTES-th byte of a word, text_we=1 for exactly one cycle on the cycle after that rx_done, with text_waddr = word index and text_wdata = full word. The word index then increments.
  - After word N-1 is written -> CHECK.
  - The index never wraps: the N <= 2^ADDR_WIDTH check guarantees this.
- CHECK: byte == checksum -> DONE, otherwise -> ERROR code 1.
- DONE: cpu_rst=0, loaded=1. rx_done is ignored. boot_req -> IDLE with cpu_rst=1 on the next cycle.
- ERROR: cpu_rst=1, err=1, err_code held. A received 0xA5 -> LEN_LO and clears err/err_code. boot_req -> IDLE and clears err/err_code.
- cpu_rst=1 in every state except DONE; registered, with no combinational path from rx inputs.
- Timeout: in LEN_LO, LEN_HI, PAYLOAD and CHECK, an idle counter resets on every rx_done. When it reaches TIMEOUT -> ERROR code 3. Inactive in IDLE, DONE and ERROR.
- Simultaneous events: boot_req has priority over rx_done and over timeout in every state; the coincident byte is dropped. rx_done on the same cycle the counter reaches TIMEOUT counts as a byte, not a timeout.
- Width rules:
  - byte counter: $clog2(WORD_BYTES) bits (min 1)
  - length register: 16 bits
  - comparison against 2^ADDR_WIDTH: ADDR_WIDTH+1 bits
  - word index: ADDR_WIDTH+1 bits internally, truncated to ADDR_WIDTH for text_waddr

Decomposition:
- Package `boot_pkg`:
  - state encoding localparams
  - SYNC_BYTE = 8'hA5
  - ERR_NONE/ERR_CHK/ERR_LEN/ERR_TMO codes
- Sub-module `byte_packer` (params WIDTH, BIG_ENDIAN):
  - inputs: byte, strobe, clear
  - outputs: word, word_valid pulse
  - FSM, checksum, timeout and address counter stay in uart_boot_loader.
- Text memory gains a synchronous write port (clk, we, waddr, in). This is a separate change.

Test Plan:
- Basic load, defaults: reset, then bytes A5 02 00 13 00 00 00 93 00 10 00 90.
  - text_we pulses twice: addr 0 / 0x00000013, then addr 1 / 0x00100093.
  - loaded=1 and cpu_rst=0 one cycle after the 0x90 rx_done.
- Checksum error: same frame with CHK=0x91 -> err=1, err_code=1, cpu_rst=1, two writes performed. Then a fresh correct frame -> loaded=1, err=0.
- Length overflow: A5 01 01 -> ERROR code 2 after the third byte, no text_we. With N = 00 01 (256 words), 1024 payload bytes plus correct CHK -> last write at addr 255, loaded=1.
- Timeout and empty frame:
  - TIMEOUT=100: A5 02, then silence -> err_code=3 on cycle 100 after the last rx_done.
  - A5 00 00 00 -> DONE with zero writes.
- Big-endian: BIG_ENDIAN=1, WIDTH=16: A5 01 00 12 34 26 -> word 0x1234 at addr 0, loaded=1.
- Priority and reset: boot_req and rx_done=0xA5 on the same cycle in DONE -> IDLE, byte dropped, cpu_rst=1. rst asserted mid-PAYLOAD -> all outputs at reset values in the same cycle, no further text_we.
